// File: rtl/sdram_burst_arbiter.sv
// Burst-locked arbiter sharing one SDRAM Avalon-MM port between the VGA reader (priority) and the stream writer.
// States: IDLE arbitrate | VGA_CMD issue read | VGA_DATA collect beats | STRM write beats. `SDRAM_ARB_STATS_EN adds burst counters.
module sdram_burst_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int BCW            = 6,
    parameter int VGA_STREAK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     vga_address,
    input  logic              vga_read,
    input  logic [BCW-1:0]    vga_burstcount,
    output logic              vga_waitrequest,
    output logic [DW-1:0]     vga_readdata,
    output logic              vga_readdatavalid,
    input  logic [AW-1:0]     strm_address,
    input  logic              strm_write,
    input  logic [DW-1:0]     strm_writedata,
    input  logic [DW/8-1:0]   strm_byteenable,
    input  logic [BCW-1:0]    strm_burstcount,
    output logic              strm_waitrequest,
    output logic [AW-1:0]     sdram_address,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [DW-1:0]     sdram_writedata,
    output logic [DW/8-1:0]   sdram_byteenable,
    output logic [BCW-1:0]    sdram_burstcount,
    input  logic              sdram_waitrequest,
    input  logic [DW-1:0]     sdram_readdata,
    input  logic              sdram_readdatavalid,
    output logic [1:0]        grant
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_vga_bursts,
    output logic [15:0]       stat_strm_bursts
`endif
);

    localparam int SW = $clog2(VGA_STREAK_MAX + 1);

    typedef enum logic [1:0] {IDLE, VGA_CMD, VGA_DATA, STRM} state_t;

    state_t            state_q;
    logic [BCW-1:0]    remaining_q;
    logic              strm_first_q;
    logic [SW-1:0]     streak_q;
    logic [1:0]        grant_q;
    logic [AW-1:0]     hold_addr_q;
    logic [DW-1:0]     hold_wdata_q;
    logic [DW/8-1:0]   hold_be_q;
    logic [BCW-1:0]    hold_bc_q;

    logic              streak_full;
    logic              vga_sel;
    logic              vga_acc;
    logic              strm_acc;
    logic              vga_last;
    logic              strm_last;
    logic [BCW-1:0]    vga_bc_d;
    logic [BCW-1:0]    strm_left_d;

    assign streak_full = (streak_q == SW'(VGA_STREAK_MAX));
    assign vga_sel     = vga_read && !(strm_write && streak_full);
    assign vga_acc     = (state_q == VGA_CMD) && vga_read && !sdram_waitrequest;
    assign strm_acc    = (state_q == STRM) && strm_write && !sdram_waitrequest;
    assign vga_bc_d    = (vga_burstcount == '0) ? BCW'(1) : vga_burstcount;

    // First accepted write beat loads the beats still owed after it; later beats count down.
    always_comb begin
        strm_left_d = remaining_q - BCW'(1);
        if (strm_first_q) begin
            strm_left_d = (strm_burstcount == '0) ? '0 : strm_burstcount - BCW'(1);
        end
    end

    assign vga_last  = (state_q == VGA_DATA) && sdram_readdatavalid && (remaining_q == BCW'(1));
    assign strm_last = strm_acc && (strm_left_d == '0);

    assign vga_readdata      = sdram_readdata;
    assign vga_readdatavalid = sdram_readdatavalid;
    assign grant             = grant_q;

    always_comb begin
        sdram_address    = hold_addr_q;
        sdram_writedata  = hold_wdata_q;
        sdram_byteenable = hold_be_q;
        sdram_burstcount = hold_bc_q;
        sdram_read       = 1'b0;
        sdram_write      = 1'b0;
        vga_waitrequest  = 1'b1;
        strm_waitrequest = 1'b1;
        case (state_q)
            VGA_CMD: begin
                sdram_address    = vga_address;
                sdram_byteenable = '1;
                sdram_burstcount = vga_burstcount;
                sdram_read       = vga_read;
                vga_waitrequest  = sdram_waitrequest;
            end
            STRM: begin
                sdram_address    = strm_address;
                sdram_writedata  = strm_writedata;
                sdram_byteenable = strm_byteenable;
                sdram_burstcount = strm_burstcount;
                sdram_write      = strm_write;
                strm_waitrequest = sdram_waitrequest;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            strm_first_q <= 1'b0;
            streak_q     <= '0;
            grant_q      <= 2'b00;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_be_q    <= '0;
            hold_bc_q    <= '0;
        end else begin
            if (state_q == VGA_CMD || state_q == STRM) begin
                hold_addr_q  <= sdram_address;
                hold_wdata_q <= sdram_writedata;
                hold_be_q    <= sdram_byteenable;
                hold_bc_q    <= sdram_burstcount;
            end
            case (state_q)
                IDLE: begin
                    if (vga_sel) begin
                        state_q <= VGA_CMD;
                        grant_q <= 2'b01;
                        if (!streak_full) begin
                            streak_q <= streak_q + SW'(1);
                        end
                    end else if (strm_write) begin
                        state_q      <= STRM;
                        grant_q      <= 2'b10;
                        strm_first_q <= 1'b1;
                        streak_q     <= '0;
                    end
                end
                VGA_CMD: begin
                    if (vga_acc) begin
                        remaining_q <= vga_bc_d;
                        state_q     <= VGA_DATA;
                    end
                end
                VGA_DATA: begin
                    if (sdram_readdatavalid) begin
                        remaining_q <= remaining_q - BCW'(1);
                    end
                    if (vga_last) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                STRM: begin
                    if (strm_acc) begin
                        remaining_q  <= strm_left_d;
                        strm_first_q <= 1'b0;
                    end
                    if (strm_last) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] stat_vga_q;
    logic [15:0] stat_strm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_vga_q  <= '0;
            stat_strm_q <= '0;
        end else begin
            if (vga_last) begin
                stat_vga_q <= stat_vga_q + 16'd1;
            end
            if (strm_last) begin
                stat_strm_q <= stat_strm_q + 16'd1;
            end
        end
    end

    assign stat_vga_bursts  = stat_vga_q;
    assign stat_strm_bursts = stat_strm_q;
`endif

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: transaction-level ownership model plus directed scenarios.
`timescale 1ns/1ps
module tb_sdram_burst_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BCW  = 6;
    localparam int SMAX = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   vga_address = '0;
    logic            vga_read = 1'b0;
    logic [BCW-1:0]  vga_burstcount = '0;
    logic            vga_waitrequest;
    logic [DW-1:0]   vga_readdata;
    logic            vga_readdatavalid;
    logic [AW-1:0]   strm_address = '0;
    logic            strm_write = 1'b0;
    logic [DW-1:0]   strm_writedata = '0;
    logic [DW/8-1:0] strm_byteenable = '0;
    logic [BCW-1:0]  strm_burstcount = '0;
    logic            strm_waitrequest;
    logic [AW-1:0]   sdram_address;
    logic            sdram_read;
    logic            sdram_write;
    logic [DW-1:0]   sdram_writedata;
    logic [DW/8-1:0] sdram_byteenable;
    logic [BCW-1:0]  sdram_burstcount;
    logic            sdram_waitrequest = 1'b0;
    logic [DW-1:0]   sdram_readdata = '0;
    logic            sdram_readdatavalid = 1'b0;
    logic [1:0]      grant;
`ifdef SDRAM_ARB_STATS_EN
    logic [15:0]     stat_vga_bursts;
    logic [15:0]     stat_strm_bursts;
`endif

    always #5 clk = ~clk;

    sdram_burst_arbiter #(.AW(AW), .DW(DW), .BCW(BCW), .VGA_STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .vga_address(vga_address), .vga_read(vga_read), .vga_burstcount(vga_burstcount),
        .vga_waitrequest(vga_waitrequest), .vga_readdata(vga_readdata), .vga_readdatavalid(vga_readdatavalid),
        .strm_address(strm_address), .strm_write(strm_write), .strm_writedata(strm_writedata),
        .strm_byteenable(strm_byteenable), .strm_burstcount(strm_burstcount), .strm_waitrequest(strm_waitrequest),
        .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_writedata(sdram_writedata), .sdram_byteenable(sdram_byteenable), .sdram_burstcount(sdram_burstcount),
        .sdram_waitrequest(sdram_waitrequest), .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
        .grant(grant)
`ifdef SDRAM_ARB_STATS_EN
        , .stat_vga_bursts(stat_vga_bursts), .stat_strm_bursts(stat_strm_bursts)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the port and how many beats that burst still owes.
    int  m_owner  = 0;
    bit  m_issued = 1'b0;
    int  m_left   = 0;
    int  m_streak = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_issued = 1'b0; m_left = 0; m_streak = 0;
        end else if (m_owner == 0) begin
            if (vga_read && !(strm_write && m_streak == SMAX)) begin
                m_owner = 1; m_issued = 1'b0;
                if (m_streak < SMAX) m_streak++;
            end else if (strm_write) begin
                m_owner = 2; m_left = -1; m_streak = 0;
            end
        end else if (m_owner == 1) begin
            if (!m_issued) begin
                if (vga_read && !sdram_waitrequest) begin
                    m_issued = 1'b1;
                    m_left = (vga_burstcount == 0) ? 1 : int'(vga_burstcount);
                end
            end else if (sdram_readdatavalid) begin
                m_left--;
                if (m_left == 0) m_owner = 0;
            end
        end else begin
            if (strm_write && !sdram_waitrequest) begin
                if (m_left < 0) m_left = (strm_burstcount == 0) ? 1 : int'(strm_burstcount);
                m_left--;
                if (m_left == 0) m_owner = 0;
            end
        end
    end

    // SDRAM read responder: first beat 3 cycles after acceptance, then one beat per cycle; ignores reset.
    bit            rd_acc = 1'b0;
    int            rd_bc_s = 0;
    int            rd_left = 0;
    int            rd_wait = 0;
    logic [DW-1:0] rd_seq = 32'hD000_0000;
    bit            wr_toggle = 1'b0;

    always @(negedge clk) begin
        rd_acc  = sdram_read && !sdram_waitrequest;
        rd_bc_s = int'(sdram_burstcount);
    end

    always @(posedge clk) begin
        #1;
        if (rd_acc) begin
            rd_left = (rd_bc_s == 0) ? 1 : rd_bc_s;
            rd_wait = 3;
        end
        if (rd_left > 0 && rd_wait == 0) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = rd_seq;
            rd_seq              = rd_seq + 32'd1;
            rd_left--;
        end else begin
            sdram_readdatavalid = 1'b0;
            if (rd_wait > 0) rd_wait--;
        end
        sdram_waitrequest = wr_toggle ? ~sdram_waitrequest : 1'b0;
    end

    // Observers of DUT activity for the directed checks.
    int            vga_beats = 0;
    int            s_acc = 0;
    logic [DW-1:0] d_wdata[$];
    int            d_grants[$];
    logic [1:0]    prev_grant = 2'b00;

    always @(negedge clk) begin
        if (vga_readdatavalid) vga_beats++;
        if (sdram_write && !sdram_waitrequest) begin
            s_acc++;
            d_wdata.push_back(sdram_writedata);
        end
        if (grant != 2'b00 && prev_grant == 2'b00) d_grants.push_back(int'(grant));
        prev_grant = grant;
    end

    logic [1:0] eg;
    logic       evw, esw, erd, ewr;

    always @(negedge clk) begin
        chk("rvalid_pass", longint'(vga_readdatavalid), longint'(sdram_readdatavalid));
        chk("rdata_pass", longint'(vga_readdata), longint'(sdram_readdata));
        if (rst) begin
            eg = 2'b00; evw = 1'b1; esw = 1'b1; erd = 1'b0; ewr = 1'b0;
        end else begin
            eg  = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            evw = (m_owner == 1 && !m_issued) ? sdram_waitrequest : 1'b1;
            esw = (m_owner == 2) ? sdram_waitrequest : 1'b1;
            erd = (m_owner == 1 && !m_issued && vga_read);
            ewr = (m_owner == 2 && strm_write);
        end
        chk("grant", longint'(grant), longint'(eg));
        chk("vga_waitrequest", longint'(vga_waitrequest), longint'(evw));
        chk("strm_waitrequest", longint'(strm_waitrequest), longint'(esw));
        chk("sdram_read", longint'(sdram_read), longint'(erd));
        chk("sdram_write", longint'(sdram_write), longint'(ewr));
        if (erd) begin
            chk("rd_address", longint'(sdram_address), longint'(vga_address));
            chk("rd_burstcount", longint'(sdram_burstcount), longint'(vga_burstcount));
        end
        if (ewr) begin
            chk("wr_address", longint'(sdram_address), longint'(strm_address));
            chk("wr_data", longint'(sdram_writedata), longint'(strm_writedata));
            chk("wr_byteenable", longint'(sdram_byteenable), longint'(strm_byteenable));
            chk("wr_burstcount", longint'(sdram_burstcount), longint'(strm_burstcount));
        end
    end

    task automatic wait_idle(string name);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (grant == 2'b00) break;
        end
        chk(name, longint'(grant), 0);
    endtask

    task automatic vga_req(logic [AW-1:0] a, logic [BCW-1:0] bc);
        @(posedge clk); #1;
        vga_address = a; vga_burstcount = bc; vga_read = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (grant == 2'b01 && !vga_waitrequest) break;
        end
        @(posedge clk); #1;
        vga_read = 1'b0;
    endtask

    task automatic strm_burst(logic [AW-1:0] a, int bc, logic [DW-1:0] base);
        int k = 0;
        @(posedge clk); #1;
        strm_address = a; strm_burstcount = BCW'(bc); strm_byteenable = 4'hA;
        strm_writedata = base; strm_write = 1'b1;
        for (int t = 0; t < 300 && k < bc; t++) begin
            @(negedge clk);
            if (grant == 2'b10 && !strm_waitrequest) k++;
            @(posedge clk); #1;
            strm_writedata = base + DW'(k);
        end
        @(negedge clk);
        chk("strm_write_after_last", longint'(sdram_write), 0);
        chk("strm_idle_after_last", longint'(grant), 0);
        strm_write = 1'b0;
    endtask

    int b0;
    int s0;
    int g0;
    int exp_seq[6] = '{1, 1, 2, 1, 1, 2};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_grant", longint'(grant), 0);
        chk("reset_vga_wait", longint'(vga_waitrequest), 1);
        chk("reset_strm_wait", longint'(strm_waitrequest), 1);
        chk("reset_read", longint'(sdram_read), 0);
        chk("reset_write", longint'(sdram_write), 0);
        rst = 1'b0;

        // VGA-only burst of 8
        b0 = vga_beats;
        @(posedge clk); #1;
        vga_address = 32'h0000_0100; vga_burstcount = 6'd8; vga_read = 1'b1;
        @(negedge clk);
        chk("vga_grant_before_edge", longint'(grant), 0);
        @(negedge clk);
        chk("vga_grant_after_edge", longint'(grant), 1);
        chk("vga_cmd_read", longint'(sdram_read), 1);
        @(posedge clk); #1;
        vga_read = 1'b0;
        wait_idle("vga8_idle");
        chk("vga8_beats", longint'(vga_beats - b0), 8);

        // Stream burst of 4 with toggling backpressure
        s0 = s_acc;
        d_wdata.delete();
        wr_toggle = 1'b1;
        strm_burst(32'h0000_2000, 4, 32'hA000_0000);
        wr_toggle = 1'b0;
        chk("strm4_accepts", longint'(s_acc - s0), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < d_wdata.size())
                chk($sformatf("strm4_data%0d", i), longint'(d_wdata[i]), longint'(32'hA000_0000 + i));
        end

        // Contention with streak limit 2
        g0 = d_grants.size();
        @(posedge clk); #1;
        vga_address = 32'h0000_3000; vga_burstcount = 6'd1; vga_read = 1'b1;
        strm_address = 32'h0000_4000; strm_burstcount = 6'd1; strm_writedata = 32'h5555_0000; strm_write = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk); #1;
            if (d_grants.size() >= g0 + 6 && grant == 2'b00) break;
        end
        vga_read = 1'b0; strm_write = 1'b0;
        chk("contention_grants", longint'(d_grants.size() - g0), 6);
        for (int i = 0; i < 6; i++) begin
            if (g0 + i < d_grants.size())
                chk($sformatf("contention_seq%0d", i), longint'(d_grants[g0 + i]), longint'(exp_seq[i]));
        end

        // Burstcount 0 (VGA) and 1 (stream)
        b0 = vga_beats;
        vga_req(32'h0000_5000, 6'd0);
        wait_idle("vga0_idle");
        chk("vga0_beats", longint'(vga_beats - b0), 1);
        s0 = s_acc;
        strm_burst(32'h0000_6000, 1, 32'hB000_0000);
        chk("strm1_accepts", longint'(s_acc - s0), 1);

`ifdef SDRAM_ARB_STATS_EN
        chk("stat_vga_bursts", longint'(stat_vga_bursts), 6);
        chk("stat_strm_bursts", longint'(stat_strm_bursts), 4);
`endif

        // Reset in the middle of a VGA data phase
        b0 = vga_beats;
        vga_req(32'h0000_7000, 6'd8);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if (vga_beats - b0 >= 3) break;
        end
        rst = 1'b1;
        #1;
        chk("midrst_grant", longint'(grant), 0);
        chk("midrst_vga_wait", longint'(vga_waitrequest), 1);
        chk("midrst_strm_wait", longint'(strm_waitrequest), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk); #1;
            if (vga_beats - b0 >= 8) break;
        end
        chk("midrst_late_beats", longint'(vga_beats - b0), 8);
        b0 = vga_beats;
        vga_req(32'h0000_8000, 6'd2);
        wait_idle("after_rst_idle");
        chk("after_rst_beats", longint'(vga_beats - b0), 2);

`ifdef SDRAM_ARB_STATS_EN
        chk("stat_vga_after_rst", longint'(stat_vga_bursts), 1);
        chk("stat_strm_after_rst", longint'(stat_strm_bursts), 0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d comparisons failed", n_fail, n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
